// File: rtl/pac_sprite_ctrl.sv
// Purpose: per-frame controller for the Pac-Man sprite shifter; issues shifter
//          enable/rotation, paces the mouth chomp and streams the 5x5 sprite.
// Latency: tick -> SHIFT +1, LOAD +2, first pixel +3, done +28 with no stalls.
// Backpressure: pixel stream is valid/ready; a stalled pixel holds x/y/colour
//               and adds one cycle per stall. One tick is queued as pending
//               while busy; a second queued tick is dropped and flags overrun.
//
// Ports:
//   clock, resetn           clock and asynchronous active-low reset
//   frame_tick              one-cycle pulse per video frame
//   dir_req[3:0]            one-hot joystick request {down, left, up, right}
//   moving                  enables chomp counting on the start edge
//   sprite[24:0]            shifter output, row 0 in sprite[24:20]
//   shift_en, rotation      shifter controls (rotation: 0 R, 1 U, 2 L, 3 D)
//   plot_x/y/colour/valid   pixel stream to the plotter, plot_ready accepts
//   busy, done, overrun     status: not idle, draw finished, tick lost

module pac_sprite_ctrl #(
    parameter int CHOMP_DIV = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic [3:0]  dir_req,
    input  logic        moving,
    input  logic [24:0] sprite,
    output logic        shift_en,
    output logic [1:0]  rotation,
    output logic [2:0]  plot_x,
    output logic [2:0]  plot_y,
    output logic        plot_colour,
    output logic        plot_valid,
    input  logic        plot_ready,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        LOAD  = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(CHOMP_DIV - 1);

    state_t      state;
    logic        pending;
    logic [7:0]  chomp_cnt;
    logic [4:0]  pix_idx;
    // Holds the sprite captured in LOAD; shifted left on every accepted
    // pixel so the next pixel's colour is always at bit 23.
    logic [24:0] snapshot;

    logic        start;
    logic [1:0]  rot_next;
    logic        chomp_wrap;
    logic [7:0]  cnt_next;

    assign start = frame_tick || pending;

    // Only a single set bit selects a new direction; anything else keeps
    // the current heading.
    always_comb begin
        rot_next = rotation;
        case (dir_req)
            4'b0001: rot_next = 2'd0;
            4'b0010: rot_next = 2'd1;
            4'b0100: rot_next = 2'd2;
            4'b1000: rot_next = 2'd3;
            default: rot_next = rotation;
        endcase
    end

    always_comb begin
        chomp_wrap = moving && (chomp_cnt == CNT_MAX);
        cnt_next   = chomp_cnt;
        if (moving) begin
            cnt_next = chomp_wrap ? 8'd0 : chomp_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            chomp_cnt   <= 8'd0;
            rotation    <= 2'd0;
            shift_en    <= 1'b0;
            pix_idx     <= 5'd0;
            snapshot    <= 25'd0;
            plot_x      <= 3'd0;
            plot_y      <= 3'd0;
            plot_colour <= 1'b0;
            plot_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            shift_en <= 1'b0;
            done     <= 1'b0;

            // Queue one tick that arrives while busy; a second is lost.
            if (frame_tick && state != IDLE) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        pending   <= 1'b0;
                        rotation  <= rot_next;
                        chomp_cnt <= cnt_next;
                        // A heading change forces a shift so the shifter
                        // lands on the new direction's open-mouth frame.
                        shift_en  <= chomp_wrap || (rot_next != rotation);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    state <= LOAD;
                end

                LOAD: begin
                    // Sprite here already reflects the shift from SHIFT.
                    snapshot    <= sprite;
                    pix_idx     <= 5'd0;
                    plot_x      <= 3'd0;
                    plot_y      <= 3'd0;
                    plot_colour <= sprite[24];
                    plot_valid  <= 1'b1;
                    state       <= DRAW;
                end

                DRAW: begin
                    if (plot_ready) begin
                        if (pix_idx == 5'd24) begin
                            plot_valid  <= 1'b0;
                            plot_colour <= 1'b0;
                            plot_x      <= 3'd0;
                            plot_y      <= 3'd0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            pix_idx     <= pix_idx + 5'd1;
                            snapshot    <= {snapshot[23:0], 1'b0};
                            plot_colour <= snapshot[23];
                            if (plot_x == 3'd4) begin
                                plot_x <= 3'd0;
                                plot_y <= plot_y + 3'd1;
                            end else begin
                                plot_x <= plot_x + 3'd1;
                            end
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    plot_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pac_sprite_ctrl.md
# pac_sprite_ctrl

Per-frame controller for the Pac-Man sprite shifter. It turns a frame tick and joystick direction requests into the shifter's `enable`/`rotation` controls. It paces the mouth-chomp animation and serialises the resulting 5x5 sprite into a pixel stream for the VGA plotter using a valid/ready handshake. It sits between the game-timing logic and the shifter/plotter pair.

## Interface
Parameters:
- `CHOMP_DIV`, default 8: processed frames per mouth toggle while moving; legal range 1–255.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `dir_req`  in  4  one-hot joystick request, bit order {down, left, up, right}.
- `moving`  in  1  high when Pac-Man is moving; enables chomp counting.
- `sprite`  in  25  current shifter output; row 0 is `sprite[24:20]`.
- `shift_en`  out  1  one-cycle enable to the shifter.
- `rotation`  out  2  registered rotation to the shifter: 0 = right, 1 = up, 2 = left, 3 = down.
- `plot_x`  out  3  pixel column offset, 0–4.
- `plot_y`  out  3  pixel row offset, 0–4.
- `plot_colour`  out  1  sprite bit for the current pixel.
- `plot_valid`  out  1  pixel available.
- `plot_ready`  in  1  plotter accepts the pixel this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last pixel is accepted.
- `overrun`  out  1  sticky; set when a frame tick is lost.

## Operation
- FSM states: IDLE → SHIFT → LOAD → DRAW → DONE → IDLE.
- **IDLE**
  - A cycle starts when `frame_tick` is high or `pending` is set.
  - On the start edge:
    - Clear `pending`.
    - Sample `dir_req`. Exactly one bit set → `rotation` takes the encoded direction. Zero bits or multiple bits → `rotation` holds.
    - If `moving`=1: `chomp_cnt` increments, wrapping from `CHOMP_DIV-1` to 0.
    - Next state is SHIFT.
- **SHIFT**
  - `shift_en`=1 for exactly this cycle when the chomp counter wrapped, or when `rotation` changed value on the start edge. Otherwise `shift_en`=0.
  - A rotation change therefore forces the shifter onto the new direction's open-mouth frame.
  - Next state is LOAD.
- **LOAD**
  - Capture `sprite` into a 25-bit snapshot register.
  - Set pixel index `i` = 0. Next state is DRAW.
- **DRAW**
  - `plot_valid`=1.
  - `plot_x` = i mod 5, `plot_y` = i / 5, `plot_colour` = snapshot[24-i].
  - When `plot_valid` && `plot_ready`, advance `i`. Accepting pixel at i = 24 moves the FSM to DONE.
  - While `plot_ready`=0, x, y and colour hold stable.
- **DONE**
  - `done`=1 for one cycle. Next state is IDLE.
- **Pending tick**
  - A `frame_tick` in any non-IDLE state sets `pending`.
  - If `pending` is already set, the tick is dropped and `overrun` is set to 1. `overrun` is cleared only by reset.
- **Reset**
  - Asynchronous assertion forces every register to its reset value immediately.
  - A reset during DRAW aborts the draw; no `done` pulse is produced.
  - Reset values:
    - state = IDLE.
    - `rotation` = 0, `chomp_cnt` = 0.
    - `shift_en`, `plot_valid`, `plot_colour`, `done`, `busy`, `overrun` = 0.
    - `plot_x` = `plot_y` = 0.
    - `pending` = 0, snapshot = 0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- With a `frame_tick` in cycle 0 while IDLE:
  - SHIFT in cycle 1 (`shift_en` if due); the shifter updates at the end of cycle 1.
  - LOAD in cycle 2: snapshot taken from the post-shift `sprite`.
  - DRAW begins in cycle 3: first `plot_valid` cycle.
- With `plot_ready` held at 1:
  - Pixels are accepted in cycles 3–27.
  - `done` is high in cycle 28 and the FSM is IDLE in cycle 29.
  - `busy` is high in cycles 1–28.
- Each stalled cycle (`plot_ready`=0) adds exactly one cycle to the draw.
- A pending tick starts the next cycle on the first IDLE cycle. There is no dead cycle between DONE and the new SHIFT beyond that IDLE cycle.
- `dir_req` and `moving` are sampled only on the start edge.

## Test plan
- Reset, then tick with `dir_req`=0001, `moving`=1, `CHOMP_DIV`=8, ready=1 → no `shift_en` on the first tick; `shift_en` in cycle 1 of the 8th tick; 25 pixels in raster order (x 0–4 then y+1); `done` in cycle 28.
- Tick with `dir_req`=0010 after `rotation`=0 → `rotation`=1 and `shift_en`=1 in cycle 1 regardless of the chomp count.
- `dir_req`=0110 (two bits set) or 0000 → `rotation` unchanged and no direction-driven `shift_en`.
- `plot_ready` toggled 0/1 every cycle during DRAW → each pixel held until accepted; `done` after 50 DRAW cycles; snapshot unaffected by `sprite` changes mid-draw.
- Two ticks during one draw → the first sets `pending` and the next cycle starts immediately after IDLE; the second sets `overrun`=1, which stays set until reset.
- `resetn` pulsed low at pixel 12 → all outputs are 0 immediately; no `done`; the next tick draws starting from pixel 0 with `rotation`=0.
